// File: rtl/s2p_pkg.sv
// Shared types and default parameters for the serial-to-parallel deserializer.
package s2p_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam int N_DEF       = 4;
  localparam int DEPTH_DEF   = 2;
  localparam int GAP_MAX_DEF = 3;

endpackage

// File: rtl/s2p_fifo.sv
// Word buffer for the deserializer. The head word is held in a register so
// that it keeps its last value while the buffer is empty.
module s2p_fifo #(
  parameter int N     = 4,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic         pop,
  input  logic [N-1:0] wdata,
  output logic         full,
  output logic         empty,
  output logic [N-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [N-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  head_q, head_d;
  logic          push_ok, pop_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = head_q;

  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    head_d   = head_q;
    // A push into a buffer that is (or becomes) empty is the new head directly.
    if (count_d != '0) begin
      if (push_ok && (count_q == CW'(pop_ok)))
        head_d = wdata;
      else
        head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/s2p_deserializer.sv
// Serial-to-parallel deserializer: MSB-first bit assembly with gap timeout,
// feeding a small output buffer with overrun detection.
module s2p_deserializer
  import s2p_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int GAP_MAX = GAP_MAX_DEF
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         ser_valid,
  input  logic         ser_data,
  output logic         par_valid,
  output logic [N-1:0] par_data,
  input  logic         par_ready,
  output logic         overrun,
  output logic         frame_err
);

  localparam int BW = $clog2(N + 1);
  localparam int GW = $clog2(GAP_MAX + 2);

  state_e        state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [N-1:0]  shift_q, shift_d;
  logic          overrun_q, overrun_d;
  logic          frame_err_q, frame_err_d;
  logic [BW-1:0] cnt_inc;
  logic [N-1:0]  word;
  logic          push, pop, full, empty;

  assign pop       = par_ready && !empty;
  assign par_valid = !empty;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    cnt_inc     = bit_cnt_q + BW'(1);
    word        = (shift_q << 1) | N'(ser_data);
    // IDLE has a zero bit count, so accepting a bit is identical in every state.
    if (ser_valid) begin
      gap_cnt_d = '0;
      if (cnt_inc == BW'(N)) begin
        push      = 1'b1;
        bit_cnt_d = '0;
        shift_d   = '0;
        state_d   = IDLE;
      end else begin
        bit_cnt_d = cnt_inc;
        shift_d   = word;
        state_d   = SHIFT;
      end
    end else begin
      case (state_q)
        SHIFT: begin
          gap_cnt_d = GW'(1);
          state_d   = GAP;
        end
        GAP: begin
          if (gap_cnt_q >= GW'(GAP_MAX)) begin
            frame_err_d = 1'b1;
            bit_cnt_d   = '0;
            gap_cnt_d   = '0;
            shift_d     = '0;
            state_d     = IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + GW'(1);
          end
        end
        default: ;
      endcase
    end
    overrun_d = push && full && !pop;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      shift_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      shift_q     <= shift_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  s2p_fifo #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .wdata (word),
    .full  (full),
    .empty (empty),
    .head  (par_data)
  );

endmodule

// File: tb/tb_s2p_deserializer.sv
// Directed scoreboard bench for s2p_deserializer with default parameters.
module tb_s2p_deserializer;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rstn;
  logic         ser_valid;
  logic         ser_data;
  logic         par_ready;
  logic         par_valid;
  logic [N-1:0] par_data;
  logic         overrun;
  logic         frame_err;

  int tests = 0;
  int fails = 0;
  int ovr_cnt = 0;
  int fe_cnt = 0;
  int ovr0, fe0;
  logic [N-1:0] exp_q [$];
  logic         hold_v = 1'b0;
  logic [N-1:0] hold_d;

  s2p_deserializer #(.N(N), .DEPTH(2), .GAP_MAX(3)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .ser_valid (ser_valid),
    .ser_data  (ser_data),
    .par_valid (par_valid),
    .par_data  (par_data),
    .par_ready (par_ready),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: pop expected words on every handshake, watch pulses and hold.
  always @(negedge clk) begin
    if (rstn) begin
      if (overrun) ovr_cnt++;
      if (frame_err) fe_cnt++;
      if (hold_v && par_valid) chk("hold_stable", 32'(par_data), 32'(hold_d));
      if (par_valid && par_ready) begin
        if (exp_q.size() == 0) chk("sb_nonempty", 32'(exp_q.size()), 32'd1);
        else chk("word", 32'(par_data), 32'(exp_q.pop_front()));
      end
      hold_v = par_valid && !par_ready;
      hold_d = par_data;
    end else begin
      hold_v = 1'b0;
    end
  end

  task automatic send_bit(input logic b);
    ser_valid = 1'b1;
    ser_data  = b;
    @(posedge clk); #1;
    ser_valid = 1'b0;
  endtask

  task automatic send_word(input logic [N-1:0] w);
    for (int i = N - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic idle(input int n);
    ser_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; ser_valid = 1'b0; ser_data = 1'b0; par_ready = 1'b1;
    #12;
    chk("rst_par_valid", 32'(par_valid), 32'd0);
    chk("rst_par_data", 32'(par_data), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;

    // Back-to-back word, one-cycle latency, single-cycle par_valid.
    exp_q.push_back(4'b1011);
    send_word(4'b1011);
    @(negedge clk);
    chk("lat_valid", 32'(par_valid), 32'd1);
    chk("lat_data", 32'(par_data), 32'b1011);
    @(negedge clk);
    chk("valid_one_cycle", 32'(par_valid), 32'd0);
    drain("drain_1011");

    // Gap of two idles is tolerated.
    fe0 = fe_cnt;
    exp_q.push_back(4'b1100);
    send_bit(1'b1); send_bit(1'b1);
    idle(2);
    send_bit(1'b0); send_bit(1'b0);
    idle(3);
    drain("drain_1100");
    chk("gap_no_frame_err", 32'(fe_cnt), 32'(fe0));

    // Four idles inside a word raise frame_err on the fourth.
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    idle(3);
    @(negedge clk);
    chk("fe_not_yet", 32'(frame_err), 32'd0);
    idle(1);
    @(negedge clk);
    chk("fe_pulse", 32'(frame_err), 32'd1);
    @(negedge clk);
    chk("fe_one_cycle", 32'(frame_err), 32'd0);
    chk("fe_count", 32'(fe_cnt), 32'(fe0 + 1));
    @(posedge clk); #1;
    exp_q.push_back(4'b0001);
    send_word(4'b0001);
    idle(1);
    drain("drain_0001");

    // Stalled consumer: third word overruns the full buffer.
    par_ready = 1'b0;
    ovr0 = ovr_cnt;
    exp_q.push_back(4'b0101);
    exp_q.push_back(4'b0010);
    send_word(4'b0101);
    send_word(4'b0010);
    send_word(4'b1000);
    idle(2);
    chk("ovr_count", 32'(ovr_cnt), 32'(ovr0 + 1));
    @(negedge clk);
    chk("ovr_head_valid", 32'(par_valid), 32'd1);
    chk("ovr_head_data", 32'(par_data), 32'b0101);
    @(posedge clk); #1;
    par_ready = 1'b1;
    drain("drain_ovr");
    idle(2);
    chk("ovr_empty_after", 32'(par_valid), 32'd0);

    // Full buffer with a pop on the completing cycle: no overrun.
    par_ready = 1'b0;
    ovr0 = ovr_cnt;
    exp_q.push_back(4'b1001);
    exp_q.push_back(4'b0110);
    exp_q.push_back(4'b1110);
    send_word(4'b1001);
    send_word(4'b0110);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    par_ready = 1'b1;
    send_bit(1'b0);
    idle(2);
    drain("drain_pop_push");
    chk("no_overrun", 32'(ovr_cnt), 32'(ovr0));

    // Reset with a buffered word and a partial word in flight.
    par_ready = 1'b0;
    fe0 = fe_cnt;
    send_word(4'b0011);
    send_bit(1'b1); send_bit(1'b1);
    rstn = 1'b0;
    #3;
    chk("mid_rst_valid", 32'(par_valid), 32'd0);
    chk("mid_rst_data", 32'(par_data), 32'd0);
    chk("mid_rst_overrun", 32'(overrun), 32'd0);
    chk("mid_rst_frame_err", 32'(frame_err), 32'd0);
    exp_q.delete();
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    par_ready = 1'b1;
    exp_q.push_back(4'b0110);
    send_word(4'b0110);
    idle(6);
    drain("drain_after_rst");
    chk("rst_no_frame_err", 32'(fe_cnt), 32'(fe0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/s2p_deserializer.md
S2P_DESERIALIZER -- requirements
Module: s2p_deserializer

Interface
REQ-001 Parameter N, default 4: bits per parallel word.
REQ-002 Parameter DEPTH, default 2: output buffer entries, power of two, at least 2.
REQ-003 Parameter GAP_MAX, default 3: maximum consecutive idle cycles allowed inside a word.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 Port rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port ser_valid, input, 1 bit: ser_data is valid this cycle.
REQ-007 Port ser_data, input, 1 bit: serial bit, MSB of the word first.
REQ-008 Port par_valid, output, 1 bit: buffer head word is presented.
REQ-009 Port par_data, output, N bits: buffer head word.
REQ-010 Port par_ready, input, 1 bit: consumer accepts the word when par_valid and par_ready are both high.
REQ-011 Port overrun, output, 1 bit: one-cycle pulse, completed word dropped because the buffer was full.
REQ-012 Port frame_err, output, 1 bit: one-cycle pulse, partial word discarded on gap timeout.

Function
REQ-013 FSM SHALL have states IDLE, SHIFT and GAP.
REQ-014 IDLE with ser_valid=1: shift in the bit, bit count becomes 1, go to SHIFT; N=1 completes the word immediately and the FSM stays in IDLE.
REQ-015 SHIFT with ser_valid=1: shift left with ser_data into the LSB and increment the count; on the Nth bit, complete the word, clear the count and go to IDLE.
REQ-016 SHIFT with ser_valid=0: go to GAP and load the gap counter with 1.
REQ-017 GAP with ser_valid=1: accept the bit exactly as in SHIFT and return to SHIFT (or to IDLE if the word completes).
REQ-018 GAP with ser_valid=0: increment the gap counter; when it would exceed GAP_MAX, discard the partial word, pulse frame_err for one cycle, clear the count and go to IDLE.
REQ-019 Word completion: push the word to the buffer in the same cycle as the last bit is received, so par_valid rises on the following cycle when the buffer was empty; latency is 1 cycle from the last bit.
REQ-020 Buffer full at completion with no pop in the same cycle: drop the word, pulse overrun, leave buffer contents unchanged.
REQ-021 Buffer full at completion with a pop in the same cycle: accept the push; overrun stays 0.
REQ-022 par_data SHALL remain stable while par_valid=1 and par_ready=0.
REQ-023 Buffer empty: par_valid=0 and par_data holds its last value; a pop on an empty buffer is ignored.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH; the occupancy count spans 0..DEPTH.
REQ-025 Bits arriving on the cycle of a frame_err pulse SHALL NOT exist by construction, because the error is raised only when ser_valid=0.

Reset
REQ-026 Asserting rstn low SHALL asynchronously force: state IDLE, bit and gap counts 0, shift register 0, buffer empty, par_valid 0, par_data 0, overrun 0, frame_err 0.
REQ-027 Reset mid-word or with the buffer non-empty SHALL discard all contents; no error pulse is produced.
REQ-028 After rstn deasserts, the first ser_valid bit SHALL be treated as the MSB of a new word.

Structure
REQ-029 Package s2p_pkg SHALL hold the state enum (IDLE, SHIFT, GAP) and the default parameter constants.
REQ-030 The buffer SHALL be a separate sub-module s2p_fifo (parameters N and DEPTH; push, pop, full, empty, head); the FSM and shift logic stay in s2p_deserializer.

Verification
REQ-031 Bits 1,0,1,1 on 4 consecutive cycles with par_ready=1 -> par_valid for exactly 1 cycle with par_data=4'b1011, 1 cycle after the last bit.
REQ-032 Bits 1,1 then 2 idle cycles then 0,0 -> par_data=4'b1100, frame_err stays 0.
REQ-033 Bits 1,1,1 then 4 idle cycles -> frame_err pulses once on the 4th idle cycle; the next word 0,0,0,1 yields 4'b0001.
REQ-034 par_ready=0, three words 0101, 0010, 1000 -> buffer holds 0101 and 0010, overrun pulses on the third word; raising par_ready then gives 0101 followed by 0010.
REQ-035 Buffer full with par_ready=1 on the cycle the third word completes -> no overrun, words delivered in order.
REQ-036 rstn pulsed low after 2 bits of a word -> all outputs 0, buffer empty; the next word 0110 is received intact.
